avmm_gpio_pio: RTL and testbench
================================

AVMM_GPIO_PIO -- requirements
Module: avmm_gpio_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of GPIO bits, legal 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: clk cycles per debounce sample tick, legal 1..65535.
REQ-003 SHALL have parameter EDGE_TYPE, default 0: edge that sets a capture bit (0 = rising, 1 = falling, 2 = any).
REQ-004 SHALL have parameter RESET_OUT, default 0: reset value of the output register (WIDTH bits).
REQ-005 clk  in  1  the block's single clock.
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 address  in  3  Avalon-MM word address.
REQ-008 read  in  1  read strobe.
REQ-009 write  in  1  write strobe.
REQ-010 writedata  in  32  write data.
REQ-011 readdata  out  32  read data, registered.
REQ-012 irq  out  1  level interrupt, active-high.
REQ-013 gpio_in  in  WIDTH  asynchronous pad inputs.
REQ-014 gpio_out  out  WIDTH  output register value.
REQ-015 gpio_oe  out  WIDTH  per-bit output enable; 1 = drive.

Function
REQ-016 Register map SHALL be: 0 DATA (R: debounced input, W: output reg); 1 DIR (RW, 1 = output); 2 IRQ_MASK (RW); 3 EDGE_CAP (R; W1C); 4 OUTSET (W: out |= wd); 5 OUTCLR (W: out &= ~wd); 6-7 read 0, writes ignored.
REQ-017 Read latency SHALL be exactly 1 cycle; readdata SHALL hold its value between reads; bits above WIDTH SHALL read 0.
REQ-018 Writes SHALL take effect on the clock edge where write=1; gpio_out and gpio_oe SHALL update that same edge.
REQ-019 If read and write are asserted in the same cycle, the read SHALL return the pre-write value.
REQ-020 gpio_in SHALL pass through a 2-flop synchroniser per bit before any other use.
REQ-021 A shared prescaler SHALL count 0..DEBOUNCE_CYCLES-1 and pulse tick for one cycle at wrap.
REQ-022 Per bit, a 2-bit counter SHALL increment on each tick where the synchronised input differs from the debounced value, and clear on any tick where they match.
REQ-023 When the counter reaches 3 and a 4th differing tick occurs, the debounced bit SHALL toggle and the counter SHALL clear (accept after 4 consecutive differing ticks).
REQ-024 An edge on a debounced bit matching EDGE_TYPE SHALL set its EDGE_CAP bit the cycle after the debounced value changes.
REQ-025 A W1C write to EDGE_CAP SHALL clear only the bits written with 1; if a new edge and a clear hit the same bit in one cycle, set SHALL win.
REQ-026 irq SHALL be registered: irq = |(EDGE_CAP & IRQ_MASK), one cycle after either operand changes.
REQ-027 Bits with DIR=0 SHALL still capture edges; DIR affects only gpio_oe.

Reset
REQ-028 While reset_n=0: gpio_out=RESET_OUT, gpio_oe=0, DIR=0, IRQ_MASK=0, EDGE_CAP=0, readdata=0, irq=0, prescaler=0, counters=0, synchronisers=0, debounced=0.
REQ-029 Reset asserted mid-debounce or mid-read SHALL discard all progress; no spurious edge SHALL be captured on the first post-reset transition to a nonzero input, except as a normal debounced 0->1 edge.

Structure
REQ-030 Register address constants and EDGE_TYPE encodings SHALL live in shared package gpio_pio_pkg.
REQ-031 The per-bit synchroniser + debounce counter SHALL be one sub-module, gpio_debounce_bit, instantiated WIDTH times with a shared tick input.

Verification
REQ-032 Reset: hold reset_n=0 with gpio_in=all 1s, RESET_OUT=0x155 -> gpio_out=0x155, gpio_oe=0, irq=0, and readdata of DATA after release reads 0 until 4 ticks have elapsed.
REQ-033 Debounce: DEBOUNCE_CYCLES=4; bit 0 goes high for 3 ticks then low -> DATA stays 0, EDGE_CAP=0; bit 0 held high for 4 ticks -> DATA[0]=1 and EDGE_CAP[0]=1.
REQ-034 IRQ: IRQ_MASK=0x001, rising edge on bit 0 -> irq=1; W1C 0x001 to EDGE_CAP -> irq=0 after 1 cycle; edge on bit 1 with mask 0x001 -> irq stays 0.
REQ-035 Set/clear: write DATA=0x0F0, OUTSET=0x003, OUTCLR=0x010 -> gpio_out=0x0E3; DIR=0x3FF -> gpio_oe=0x3FF.
REQ-036 Collision: new edge on bit 2 in the same cycle as a W1C of 0x004 -> EDGE_CAP[2]=1 afterwards.
REQ-037 Map holes: read address 6 -> 0x00000000; WIDTH=32, EDGE_TYPE=2 -> both transitions on bit 31 each set EDGE_CAP[31].

Source files
------------

// File: rtl/gpio_pio_pkg.sv
// Shared constants for the Avalon-MM GPIO PIO block.
// Register word addresses and EDGE_TYPE encodings live here.
package gpio_pio_pkg;

    // Register map word addresses; 6 and 7 are holes.
    localparam logic [2:0] AddrData    = 3'd0;
    localparam logic [2:0] AddrDir     = 3'd1;
    localparam logic [2:0] AddrIrqMask = 3'd2;
    localparam logic [2:0] AddrEdgeCap = 3'd3;
    localparam logic [2:0] AddrOutSet  = 3'd4;
    localparam logic [2:0] AddrOutClr  = 3'd5;

    // EDGE_TYPE encodings.
    localparam int unsigned EdgeRise = 0;
    localparam int unsigned EdgeFall = 1;
    localparam int unsigned EdgeAny  = 2;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: 2-flop synchroniser followed by a tick-driven debouncer.
// The debounced value toggles after 4 consecutive ticks on which the
// synchronised input disagrees with it; any agreeing tick restarts the count.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   tick_i       - shared one-cycle sample tick from the prescaler
//   pad_i        - asynchronous pad input
//   deb_o        - debounced output
module gpio_debounce_bit (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_i,
    input  logic pad_i,
    output logic deb_o
);

    logic       sync1_q, sync2_q;
    logic [1:0] cnt_q, cnt_d;
    logic       deb_q, deb_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (tick_i) begin
            if (sync2_q != deb_q) begin
                if (cnt_q == 2'd3) begin
                    deb_d = ~deb_q;
                    cnt_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end else begin
                cnt_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= 2'd0;
            deb_q   <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/avmm_gpio_pio.sv
// Avalon-MM GPIO PIO: debounced inputs with edge capture and level irq,
// output register with set/clear aliases and per-bit output enable.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   address/read/write      - Avalon-MM word address and strobes
//   writedata / readdata    - 32-bit bus data; readdata is registered, 1-cycle latency
//   irq                     - registered |(EDGE_CAP & IRQ_MASK)
//   gpio_in                 - asynchronous pad inputs
//   gpio_out / gpio_oe      - output register and per-bit output enable
module avmm_gpio_pio #(
    parameter int unsigned      WIDTH           = 10,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe
);
    import gpio_pio_pkg::*;

    localparam logic [15:0] PrescMax = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      presc_q;
    logic             tick;
    logic [WIDTH-1:0] deb, deb_prev_q;
    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0] wr_data, w1c, edge_set;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q;

    assign tick    = (presc_q == PrescMax);
    assign wr_data = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_wd_unused
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        gpio_debounce_bit u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .tick_i (tick),
            .pad_i  (gpio_in[i]),
            .deb_o  (deb[i])
        );
    end

    // deb_prev_q delays the debounced vector so an edge lands in EDGE_CAP
    // the cycle after the debounced value changes.
    always_comb begin
        if (EDGE_TYPE == EdgeRise) begin
            edge_set = deb & ~deb_prev_q;
        end else if (EDGE_TYPE == EdgeFall) begin
            edge_set = ~deb & deb_prev_q;
        end else begin
            edge_set = deb ^ deb_prev_q;
        end
    end

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        w1c    = '0;
        if (write) begin
            case (address)
                AddrData:    out_d  = wr_data;
                AddrDir:     dir_d  = wr_data;
                AddrIrqMask: mask_d = wr_data;
                AddrEdgeCap: w1c    = wr_data;
                AddrOutSet:  out_d  = out_q | wr_data;
                AddrOutClr:  out_d  = out_q & ~wr_data;
                default:     ;
            endcase
        end
        // Set after clear so a coincident edge wins.
        cap_d = (cap_q & ~w1c) | edge_set;
    end

    // Reads sample register state before this edge's write lands.
    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            readdata_d = '0;
            case (address)
                AddrData:    readdata_d[WIDTH-1:0] = deb;
                AddrDir:     readdata_d[WIDTH-1:0] = dir_q;
                AddrIrqMask: readdata_d[WIDTH-1:0] = mask_q;
                AddrEdgeCap: readdata_d[WIDTH-1:0] = cap_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            deb_prev_q <= '0;
            out_q      <= RESET_OUT;
            dir_q      <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            presc_q    <= tick ? 16'd0 : presc_q + 16'd1;
            deb_prev_q <= deb;
            out_q      <= out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= |(cap_q & mask_q);
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_avmm_gpio_pio.sv
// Self-checking bench for avmm_gpio_pio. DUT A: WIDTH=10, rising edges,
// RESET_OUT=0x155. DUT B: WIDTH=32, any edge. Both use DEBOUNCE_CYCLES=4.
module tb_avmm_gpio_pio;

    localparam logic [2:0] A_DATA = 3'd0, A_DIR = 3'd1, A_MASK = 3'd2, A_CAP = 3'd3;
    localparam logic [2:0] A_SET  = 3'd4, A_CLR = 3'd5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [2:0]  address_a, address_b;
    logic        read_a, read_b, write_a, write_b, irq_a, irq_b;
    logic [31:0] writedata_a, writedata_b, readdata_a, readdata_b;
    logic [9:0]  gpio_in_a, gpio_out_a, gpio_oe_a;
    logic [31:0] gpio_in_b, gpio_out_b, gpio_oe_b;

    avmm_gpio_pio #(
        .WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_OUT(10'h155)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .address(address_a), .read(read_a),
        .write(write_a), .writedata(writedata_a), .readdata(readdata_a), .irq(irq_a),
        .gpio_in(gpio_in_a), .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a)
    );

    avmm_gpio_pio #(
        .WIDTH(32), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_OUT(32'h0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(address_b), .read(read_b),
        .write(write_b), .writedata(writedata_b), .readdata(readdata_b), .irq(irq_b),
        .gpio_in(gpio_in_b), .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b)
    );

    // Edge index since reset release; the prescaler ticks on edges where cyc % 4 == 0.
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] last_rd;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned target);
        int guard = 0;
        while (cyc < target && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != target) begin
            total++;
            bad++;
            $display("FAIL wait_cyc: reached %0d required %0d", cyc, target);
        end
    endtask

    task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
        if (sel) begin address_b = a; writedata_b = d; write_b = 1'b1; end
        else     begin address_a = a; writedata_a = d; write_a = 1'b1; end
        @(posedge clk);
        #1;
        write_a = 1'b0;
        write_b = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, input logic [31:0] e, input string nm);
        logic [31:0] got, want;
        string       n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (sel) begin address_b = a; read_b = 1'b1; end
        else     begin address_a = a; read_a = 1'b1; end
        @(posedge clk);
        #1;
        read_a = 1'b0;
        read_b = 1'b0;
        got  = sel ? readdata_b : readdata_a;
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, got, want);
        end
        last_rd = want;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        gpio_in_a = 10'h3FF;
        gpio_in_b = 32'h0;
        cycles(4);
        total++; if (gpio_out_a !== 10'h155) begin bad++; $display("FAIL rst_out: got %h expected 155", gpio_out_a); end
        total++; if (gpio_oe_a !== 10'h0) begin bad++; $display("FAIL rst_oe: got %h expected 000", gpio_oe_a); end
        total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b expected 0", irq_a); end
        total++; if (readdata_a !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h expected 0", readdata_a); end
        reset_n = 1'b1;
        rd(0, A_DATA, 32'h0, "rst_data_early");
        // Accept lands on edge 16; a read sampled on edge 14 must still see 0.
        wait_cyc(13);
        rd(0, A_DATA, 32'h0, "rst_data_3ticks");
        cycles(20);
        rd(0, A_DATA, 32'h3FF, "rst_data_accepted");
        rd(0, A_CAP, 32'h3FF, "rst_cap_rise");
        total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL rst_irq_masked: got %b expected 0", irq_a); end
        gpio_in_a = 10'h0;
        cycles(30);
        rd(0, A_DATA, 32'h0, "rst_data_low");
        wr(0, A_CAP, 32'h3FF);
        rd(0, A_CAP, 32'h0, "rst_cap_cleared");
    endtask

    task automatic test_debounce;
        gpio_in_a = 10'h001;
        cycles(12);
        gpio_in_a = 10'h000;
        cycles(30);
        rd(0, A_DATA, 32'h0, "deb_3tick_data");
        rd(0, A_CAP, 32'h0, "deb_3tick_cap");
        gpio_in_a = 10'h001;
        cycles(30);
        rd(0, A_DATA, 32'h1, "deb_4tick_data");
        rd(0, A_CAP, 32'h1, "deb_4tick_cap");
    endtask

    task automatic test_irq;
        wr(0, A_CAP, 32'h1);
        gpio_in_a = 10'h000;
        cycles(30);
        wr(0, A_MASK, 32'h1);
        cycles(2);
        total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_idle: got %b expected 0", irq_a); end
        gpio_in_a = 10'h001;
        cycles(30);
        total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b expected 1", irq_a); end
        wr(0, A_CAP, 32'h1);
        total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL irq_lag: got %b expected 1", irq_a); end
        cycles(1);
        total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_cleared: got %b expected 0", irq_a); end
        gpio_in_a = 10'h003;
        cycles(30);
        total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL irq_masked_bit1: got %b expected 0", irq_a); end
        rd(0, A_CAP, 32'h2, "irq_cap_bit1");
    endtask

    task automatic test_setclr;
        wr(0, A_DATA, 32'h0F0);
        total++; if (gpio_out_a !== 10'h0F0) begin bad++; $display("FAIL out_data: got %h expected 0f0", gpio_out_a); end
        wr(0, A_SET, 32'h003);
        wr(0, A_CLR, 32'h010);
        total++; if (gpio_out_a !== 10'h0E3) begin bad++; $display("FAIL out_setclr: got %h expected 0e3", gpio_out_a); end
        wr(0, A_DIR, 32'h3FF);
        total++; if (gpio_oe_a !== 10'h3FF) begin bad++; $display("FAIL oe_dir: got %h expected 3ff", gpio_oe_a); end
        rd(0, A_DIR, 32'h3FF, "dir_readback");
        rd(0, A_MASK, 32'h1, "mask_readback");
        rd(0, A_DATA, 32'h3, "data_is_input");
    endtask

    task automatic test_collision;
        int unsigned first;
        wr(0, A_CAP, 32'h3FF);
        rd(0, A_CAP, 32'h0, "col_cap_clear");
        // Input seen by debouncer from edge cyc+3; 4th tick toggles, cap sets one edge later.
        gpio_in_a = 10'h007;
        first = cyc + 3;
        while (first % 4 != 0) first++;
        wait_cyc(first + 12);
        wr(0, A_CAP, 32'h004);
        rd(0, A_CAP, 32'h4, "col_set_wins");
        wr(0, A_CAP, 32'h004);
        rd(0, A_CAP, 32'h0, "col_w1c_after");
    endtask

    task automatic test_holes;
        rd(0, 3'd6, 32'h0, "hole_6");
        total++; if (readdata_a !== last_rd) begin bad++; $display("FAIL hold_now: got %h expected %h", readdata_a, last_rd); end
        wr(0, 3'd7, 32'hFFFF_FFFF);
        rd(0, 3'd7, 32'h0, "hole_7");
        wr(0, 3'd6, 32'h0);
        rd(0, A_DIR, 32'h3FF, "hole_write_ignored");
        cycles(3);
        total++; if (readdata_a !== last_rd) begin bad++; $display("FAIL hold_idle: got %h expected %h", readdata_a, last_rd); end
        // Read and write of DIR in one cycle: read returns the old value.
        address_a = A_DIR; writedata_a = 32'h055; write_a = 1'b1;
        rd(0, A_DIR, 32'h3FF, "rw_same_cycle");
        rd(0, A_DIR, 32'h055, "rw_new_value");
        total++; if (gpio_oe_a !== 10'h055) begin bad++; $display("FAIL rw_oe: got %h expected 055", gpio_oe_a); end
    endtask

    task automatic test_reset_mid;
        gpio_in_a = 10'h027;
        cycles(10);
        reset_n = 1'b0;
        cycles(2);
        total++; if (gpio_out_a !== 10'h155) begin bad++; $display("FAIL mid_rst_out: got %h expected 155", gpio_out_a); end
        total++; if (gpio_oe_a !== 10'h0) begin bad++; $display("FAIL mid_rst_oe: got %h expected 000", gpio_oe_a); end
        reset_n = 1'b1;
        rd(0, A_DATA, 32'h0, "mid_rst_data");
        rd(0, A_CAP, 32'h0, "mid_rst_cap");
        wait_cyc(13);
        rd(0, A_DATA, 32'h0, "mid_rst_progress_lost");
        cycles(20);
        rd(0, A_DATA, 32'h027, "mid_rst_data_after");
        rd(0, A_CAP, 32'h027, "mid_rst_cap_after");
    endtask

    task automatic test_any_edge;
        gpio_in_b = 32'h8000_0000;
        cycles(30);
        rd(1, A_DATA, 32'h8000_0000, "b_data_hi");
        rd(1, A_CAP, 32'h8000_0000, "b_cap_rise");
        wr(1, A_CAP, 32'h8000_0000);
        rd(1, A_CAP, 32'h0, "b_cap_clear");
        gpio_in_b = 32'h0;
        cycles(30);
        rd(1, A_DATA, 32'h0, "b_data_lo");
        rd(1, A_CAP, 32'h8000_0000, "b_cap_fall");
    endtask

    initial begin
        address_a = '0; read_a = 1'b0; write_a = 1'b0; writedata_a = '0;
        address_b = '0; read_b = 1'b0; write_b = 1'b0; writedata_b = '0;
        gpio_in_a = '0; gpio_in_b = '0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_debounce;
        test_irq;
        test_setclr;
        test_collision;
        test_holes;
        test_reset_mid;
        test_any_edge;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
